// File: rtl/esc_pulse_monitor.sv
// Multi-channel ESC PWM pulse-width monitor: measures each channel's high time,
// converts (width - OFFSET) / DIV into a saturated speed through one shared
// divider, and strobes frame_rdy once every live channel has a fresh result.
// Optional stale-channel timeout: define ESC_MON_TIMEOUT_EN.
module esc_pulse_monitor #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 14,
  parameter int SPD_W       = 11,
  parameter int OFFSET      = 6250,
  parameter int DIV         = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pwm,
  output logic [NUM_CH*SPD_W-1:0] speed,
  output logic [NUM_CH-1:0]       spd_upd,
  output logic                    frame_rdy,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       stale,
  output logic [1:0]              dbg_state
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   DIV_V    = (CNT_W+1)'(DIV);
  localparam logic [31:0]      OFFSET_V = 32'(OFFSET);
  localparam logic [31:0]      SPD_MAX  = 32'((1 << SPD_W) - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;

  // pwm is asynchronous: two flops for metastability, a third for edge detect
  logic [NUM_CH-1:0] s1_q, s2_q, s3_q, rise, fall;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] width_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= '0;
        width_q[i] <= '0;
      end
    end else begin
      s1_q <= pwm;
      s2_q <= s1_q;
      s3_q <= s2_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i])                               cnt_q[i] <= CNT_W'(1);
        else if (s2_q[i] && cnt_q[i] != CNT_MAX)   cnt_q[i] <= cnt_q[i] + 1'b1;
        if (fall[i]) width_q[i] <= cnt_q[i];
      end
    end
  end

`ifdef ESC_MON_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 2);
  logic [TMR_W-1:0]  tmr_q [NUM_CH];
  logic [NUM_CH-1:0] tmo;

  // tmo marks the single cycle in which a timer reaches TIMEOUT_CYC
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      tmo[i] = !rise[i] && (tmr_q[i] == TMR_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || rise[i])     tmr_q[i] <= '0;
      else if (tmr_q[i] != '1) tmr_q[i] <= tmr_q[i] + 1'b1;
    end
  end
`endif

  logic [1:0]               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d, gch_q, gch_d;
  logic [CNT_W-1:0]         rem_q, rem_d, quo_q, quo_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [NUM_CH-1:0]        pend_q, pend_d;
  logic [NUM_CH*SPD_W-1:0]  speed_q, speed_d;
  logic [NUM_CH-1:0]        upd_q, upd_d, ovf_q, ovf_d, stale_q, stale_d;
  logic                     frame_q, frame_d;

  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx, scan_idx;
  logic [31:0]      gnt_w;
  logic [CNT_W-1:0] dividend;

  // Round-robin: lowest pending index at or above ptr, wrapping to 0
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_CH);
      if (!gnt_vld && pend_q[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt_w    = 32'(width_q[gnt_idx]);
    dividend = (gnt_w > OFFSET_V) ? CNT_W'(gnt_w - OFFSET_V) : '0;
  end

  logic [CNT_W:0] trial;
  logic [31:0]    quo_ext;
  logic           sat;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gch_d   = gch_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    pend_d  = pend_q;
    speed_d = speed_q;
    upd_d   = upd_q;
    ovf_d   = ovf_q;
    stale_d = stale_q;
    trial   = {rem_q, quo_q[CNT_W-1]};
    quo_ext = 32'(quo_q);
    sat     = quo_ext > SPD_MAX;

    // Frame clear happens first so a same-cycle WRITE counts for the next frame
    frame_d = (&(upd_q | stale_q)) && (|upd_q);
    if (frame_d) upd_d = '0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          pend_d[gnt_idx] = 1'b0;
          gch_d   = gnt_idx;
          quo_d   = dividend;
          rem_d   = '0;
          bit_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (trial >= DIV_V) begin
          rem_d = CNT_W'(trial - DIV_V);
          quo_d = {quo_q[CNT_W-2:0], 1'b1};
        end else begin
          rem_d = trial[CNT_W-1:0];
          quo_d = {quo_q[CNT_W-2:0], 1'b0};
        end
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_W'(CNT_W - 1)) state_d = WRITE;
      end
      WRITE: begin
        speed_d[gch_q*SPD_W +: SPD_W] = sat ? '1 : quo_ext[SPD_W-1:0];
        ovf_d[gch_q]   = sat;
        upd_d[gch_q]   = 1'b1;
        stale_d[gch_q] = 1'b0;
        ptr_d   = (gch_q == PTR_W'(NUM_CH - 1)) ? '0 : gch_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A capture always wins over a same-cycle grant so no width is lost
    pend_d = pend_d | fall;

`ifdef ESC_MON_TIMEOUT_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (tmo[i]) begin
        stale_d[i] = 1'b1;
        speed_d[i*SPD_W +: SPD_W] = '0;
      end
    end
`else
    stale_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gch_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      pend_q  <= '0;
      speed_q <= '0;
      upd_q   <= '0;
      ovf_q   <= '0;
      stale_q <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gch_q   <= gch_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      pend_q  <= pend_d;
      speed_q <= speed_d;
      upd_q   <= upd_d;
      ovf_q   <= ovf_d;
      stale_q <= stale_d;
      frame_q <= frame_d;
    end
  end

  assign speed     = speed_q;
  assign spd_upd   = upd_q;
  assign ovf       = ovf_q;
  assign stale     = stale_q;
  assign frame_rdy = frame_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_esc_pulse_monitor.sv
// Bench for esc_pulse_monitor: event-level reference model compared every
// cycle, plus literal expectations for the documented example scenarios.
module tb_esc_pulse_monitor;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 14;
  localparam int SPD_W       = 11;
  localparam int OFFSET      = 6250;
  localparam int DIV         = 3;
  localparam int TIMEOUT_CYC = 50000;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int SPD_MAX     = (1 << SPD_W) - 1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       pwm = '0;
  logic [NUM_CH*SPD_W-1:0] speed;
  logic [NUM_CH-1:0]       spd_upd, ovf, stale;
  logic                    frame_rdy;
  logic [1:0]              dbg_state;

  esc_pulse_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SPD_W(SPD_W), .OFFSET(OFFSET),
    .DIV(DIV), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .pwm(pwm), .speed(speed), .spd_upd(spd_upd),
    .frame_rdy(frame_rdy), .ovf(ovf), .stale(stale), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int spd(input int i);
    return int'(speed[i*SPD_W +: SPD_W]);
  endfunction

  // ---------------- reference model (event level) ----------------
  typedef struct {int at; int ch; bit fall; int width;} ev_t;
  ev_t evq[$];
  int  edge_n = 0;
  bit  model_live = 0;
  int  m_run[NUM_CH], m_width[NUM_CH], m_speed[NUM_CH], m_last_clear[NUM_CH];
  bit  m_prev[NUM_CH], m_pend[NUM_CH], m_upd[NUM_CH], m_ovf[NUM_CH], m_stale[NUM_CH];
  bit  m_busy, m_frame;
  int  m_gch, m_gdiv, m_wedge, m_ptr;

  always @(posedge clk) begin : model_blk
    int  q, idx;
    bit  found, all_cov, any_upd;
    ev_t ev;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 0; m_width[i] = 0; m_speed[i] = 0; m_last_clear[i] = edge_n;
        m_prev[i] = 0; m_pend[i] = 0; m_upd[i] = 0; m_ovf[i] = 0; m_stale[i] = 0;
      end
      evq.delete();
      m_busy = 0; m_frame = 0; m_ptr = 0;
    end else begin
      all_cov = 1; any_upd = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        all_cov = all_cov & (m_upd[i] | m_stale[i]);
        any_upd = any_upd | m_upd[i];
      end
      m_frame = all_cov && any_upd;
      if (m_frame) for (int i = 0; i < NUM_CH; i++) m_upd[i] = 0;
      // A conversion granted at edge g publishes its result at edge g+CNT_W+1
      if (m_busy && edge_n == m_wedge) begin
        q = m_gdiv / DIV;
        m_ovf[m_gch]   = (q > SPD_MAX);
        m_speed[m_gch] = (q > SPD_MAX) ? SPD_MAX : q;
        m_upd[m_gch]   = 1;
        m_stale[m_gch] = 0;
        m_ptr  = (m_gch + 1) % NUM_CH;
        m_busy = 0;
      end else if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NUM_CH; k++) begin
          idx = (m_ptr + k) % NUM_CH;
          if (!found && m_pend[idx]) begin found = 1; m_gch = idx; end
        end
        if (found) begin
          m_pend[m_gch] = 0;
          m_gdiv  = (m_width[m_gch] > OFFSET) ? m_width[m_gch] - OFFSET : 0;
          m_busy  = 1;
          m_wedge = edge_n + CNT_W + 1;
        end
      end
      while (evq.size() > 0 && evq[0].at == edge_n) begin
        ev = evq.pop_front();
        if (ev.fall) begin m_pend[ev.ch] = 1; m_width[ev.ch] = ev.width; end
        else m_last_clear[ev.ch] = edge_n;
      end
`ifdef ESC_MON_TIMEOUT_EN
      for (int i = 0; i < NUM_CH; i++)
        if (edge_n - m_last_clear[i] == TIMEOUT_CYC) begin m_stale[i] = 1; m_speed[i] = 0; end
`endif
      // Input edges take effect two clocks after they are sampled
      for (int i = 0; i < NUM_CH; i++) begin
        if (pwm[i]) begin
          if (!m_prev[i]) begin
            evq.push_back('{at: edge_n + 2, ch: i, fall: 0, width: 0});
            m_run[i] = 1;
          end else if (m_run[i] < CNT_MAX) m_run[i]++;
        end else if (m_prev[i]) begin
          evq.push_back('{at: edge_n + 2, ch: i, fall: 1, width: m_run[i]});
        end
        m_prev[i] = pwm[i];
      end
    end
    model_live = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp_blk
    logic [NUM_CH*SPD_W-1:0] e_speed;
    logic [NUM_CH-1:0]       e_upd, e_ovf, e_stale;
    if (model_live) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e_speed[i*SPD_W +: SPD_W] = SPD_W'(m_speed[i]);
        e_upd[i] = m_upd[i]; e_ovf[i] = m_ovf[i]; e_stale[i] = m_stale[i];
      end
      checks++;
      if ({speed, spd_upd, ovf, stale, frame_rdy, dbg_state == ST_IDLE} !==
          {e_speed, e_upd, e_ovf, e_stale, m_frame, !m_busy}) begin
        errors++;
        $display("FAIL cycle %0d: speed=%h upd=%b ovf=%b stale=%b frame=%b idle=%b expected speed=%h upd=%b ovf=%b stale=%b frame=%b idle=%b",
                 edge_n, speed, spd_upd, ovf, stale, frame_rdy, dbg_state == ST_IDLE,
                 e_speed, e_upd, e_ovf, e_stale, m_frame, !m_busy);
      end
    end
  end

  // ---------------- scoreboard: write order and frame pulses ----------------
  logic [1:0]        exp_q[$];
  bit                order_en = 0;
  bit                frame_with_stale3 = 0;
  int                frame_cnt = 0;
  logic [NUM_CH-1:0] prev_upd = '0;

  always @(negedge clk) begin
    if (frame_rdy) frame_cnt++;
    if (frame_rdy && stale[3]) frame_with_stale3 = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (order_en && spd_upd[i] && !prev_upd[i]) begin
        if (exp_q.size() == 0) check("write_order_extra", i, -1);
        else check("write_order", i, exp_q.pop_front());
      end
    end
    prev_upd = spd_upd;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w[NUM_CH], input int s[NUM_CH]);
    int total = 0;
    for (int i = 0; i < NUM_CH; i++) if (w[i] > 0 && s[i] + w[i] > total) total = s[i] + w[i];
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++) pwm[i] = (c >= s[i]) && (c < s[i] + w[i]);
    end
    @(posedge clk); #1;
    pwm = '0;
  endtask

  task automatic drive_aligned(input int w[NUM_CH]);
    int s[NUM_CH];
    int mx = 0;
    for (int i = 0; i < NUM_CH; i++) if (w[i] > mx) mx = w[i];
    for (int i = 0; i < NUM_CH; i++) s[i] = mx - w[i];
    drive(w, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w[NUM_CH];
    int s[NUM_CH];
    int fc, n, trials;

    rst = 1'b1;
    tick(3);
    check("reset_speed", speed, 0);
    check("reset_upd", spd_upd, 0);
    check("reset_frame", frame_rdy, 0);
    check("reset_state_idle", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick(2);

    // Simultaneous falls on all channels: round-robin from pointer 0
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(2'(i));
    order_en = 1;
    fc = frame_cnt;
    w = '{9250, 9253, 9256, 9259};
    drive_aligned(w);
    tick(120);
    order_en = 0;
    check("multi_speed0", spd(0), 1000);
    check("multi_speed1", spd(1), 1001);
    check("multi_speed2", spd(2), 1002);
    check("multi_speed3", spd(3), 1003);
    check("multi_order_done", exp_q.size(), 0);
    check("multi_frame_pulses", frame_cnt - fc, 1);
    check("multi_upd_cleared", spd_upd, 0);

    // Nominal, below-offset and saturating widths
    w = '{12250, 5000, 16000, 0};
    drive_aligned(w);
    tick(120);
    check("ch0_speed", spd(0), 2000);
    check("ch0_ovf", ovf[0], 0);
    check("ch0_upd", spd_upd[0], 1);
    check("ch1_speed", spd(1), 0);
    check("ch1_ovf", ovf[1], 0);
    check("ch2_speed", spd(2), 2047);
    check("ch2_ovf", ovf[2], 1);

`ifdef ESC_MON_TIMEOUT_EN
    // Channel 3 silent while 0-2 keep pulsing until it times out
    n = 0;
    w = '{20, 20, 20, 0};
    s = '{0, 0, 0, 0};
    while (!stale[3] && n < 70000) begin
      drive(w, s);
      tick(40);
      n += 61;
    end
    check("stale3_set", stale[3], 1);
    drive(w, s);
    tick(120);
    check("stale3_speed", spd(3), 0);
    check("stale3_frame", frame_with_stale3, 1);
    trials = 1;
`else
    trials = 4;
`endif

    // Reset during DIVIDE abandons the conversion
    w = '{300, 0, 0, 0};
    drive_aligned(w);
    n = 0;
    while (dbg_state != ST_DIVIDE && n < 60) begin tick(1); n++; end
    check("reach_divide", dbg_state, ST_DIVIDE);
    tick(5);
    rst = 1'b1;
    tick(2);
    check("rst_speed", speed, 0);
    check("rst_upd", spd_upd, 0);
    check("rst_ovf", ovf, 0);
    check("rst_stale", stale, 0);
    check("rst_frame", frame_rdy, 0);
    check("rst_state_idle", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick(2);
    w = '{12250, 0, 0, 0};
    drive_aligned(w);
    tick(60);
    check("post_rst_speed0", spd(0), 2000);
    check("post_rst_ovf0", ovf[0], 0);

    // Dense random toggling: many short pulses and overwrites of pending widths
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++) if ($urandom_range(0, 7) == 0) pwm[i] = ~pwm[i];
    end
    pwm = '0;
    tick(120);

    // Random skewed pulses spanning the offset boundary
    for (int t = 0; t < trials; t++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        w[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(6240, 6600)) : int'($urandom_range(1, 300));
        s[i] = int'($urandom_range(0, 40));
      end
      drive(w, s);
      tick(150);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
